// File: rtl/exe_stall_ctrl_pkg.sv
// Shared constants and FSM encoding for the EXE-stage divide sequencer.
package exe_stall_ctrl_pkg;

    // Divider latency, shared with the iterative divider.
    localparam int unsigned DefaultDivCycles = 33;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

endpackage

// File: rtl/exe_stall_ctrl_hazard_detect.sv
// Load-use compare between the load in EXE and the source registers in ID.
module exe_stall_ctrl_hazard_detect (
    input  logic       exe_load,
    input  logic       exe_wreg,
    input  logic [4:0] exe_dst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    assign lu = exe_load & exe_wreg & (exe_dst != 5'd0) &
                ((exe_dst == id_rs) | (exe_dst == id_rt));

endmodule

// File: rtl/exe_stall_ctrl.sv
// Divider sequencing plus ID/EXE hold, bubble and IF/ID stall generation.
module exe_stall_ctrl
    import exe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DefaultDivCycles,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_is_div,
    input  logic        exe_is_sign_div,
    input  logic        irq,
    input  logic        flush,
    input  logic        exe_load,
    input  logic        exe_wreg,
    input  logic [4:0]  exe_dst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_cancel,
    output logic        div_res_valid,
    output logic        stall0,
    output logic        clr0,
    output logic        ifid_stall,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             kill;
    logic             lu;

    assign kill = irq | flush;

    exe_stall_ctrl_hazard_detect u_hazard_detect (
        .exe_load (exe_load),
        .exe_wreg (exe_wreg),
        .exe_dst  (exe_dst),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .lu       (lu)
    );

    // Outputs are forced low during reset so no stray pulse escapes that cycle.
    always_comb begin
        div_start     = 1'b0;
        div_signed    = 1'b0;
        div_cancel    = 1'b0;
        div_res_valid = 1'b0;
        stall0        = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            unique case (state)
                StIdle: begin
                    if (exe_is_div && !kill) begin
                        div_start  = 1'b1;
                        div_signed = exe_is_sign_div;
                        stall0     = 1'b1;
                    end
                end
                StBusy: begin
                    busy = 1'b1;
                    // Kill wins over completion when both land together.
                    if (kill) begin
                        div_cancel = 1'b1;
                    end else if (cnt == '0) begin
                        div_res_valid = 1'b1;
                    end else begin
                        stall0 = 1'b1;
                    end
                end
            endcase
        end
        clr0       = !rst && lu && !stall0 && !kill;
        ifid_stall = stall0 | clr0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            stall_cycles <= 32'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (exe_is_div && !kill) begin
                        state <= StBusy;
                        cnt   <= CNT_W'(DIV_CYCLES - 1);
                    end
                end
                StBusy: begin
                    if (kill) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
            if ((stall0 || clr0) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_exe_stall_ctrl.sv
// Self-checking bench for exe_stall_ctrl: IDLE vector table plus divide sequences.
module tb_exe_stall_ctrl;

    localparam int DC = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_is_div, exe_is_sign_div, irq, flush, exe_load, exe_wreg;
    logic [4:0]  exe_dst, id_rs, id_rt;
    logic        div_start, div_signed, div_cancel, div_res_valid;
    logic        stall0, clr0, ifid_stall, busy;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    exe_stall_ctrl #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .exe_is_div      (exe_is_div),
        .exe_is_sign_div (exe_is_sign_div),
        .irq             (irq),
        .flush           (flush),
        .exe_load        (exe_load),
        .exe_wreg        (exe_wreg),
        .exe_dst         (exe_dst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .div_start       (div_start),
        .div_signed      (div_signed),
        .div_cancel      (div_cancel),
        .div_res_valid   (div_res_valid),
        .stall0          (stall0),
        .clr0            (clr0),
        .ifid_stall      (ifid_stall),
        .busy            (busy),
        .stall_cycles    (stall_cycles)
    );

    typedef struct packed {
        logic       rst, div, sdiv, irq, flush, load, wreg;
        logic [4:0] dst, rs, rt;
    } in_t;

    typedef struct packed {
        logic st, sg, ca, va, s0, c0, ifd, bs;
    } out_t;

    typedef struct {
        out_t  e;
        out_t  m;
        string nm;
    } sb_t;

    typedef struct {
        in_t   i;
        out_t  e;
        string nm;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[11];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_sc;

    localparam out_t ALL   = 8'hFF;
    localparam out_t PULSE = 8'b1011_0000;  // start, cancel, res_valid
    localparam out_t ZERO  = 8'h00;

    function automatic in_t mi(input logic r, d, sd, iq, fl, ld, wr,
                               input logic [4:0] dst, rs, rt);
        in_t v;
        v = '{r, d, sd, iq, fl, ld, wr, dst, rs, rt};
        return v;
    endfunction

    function automatic out_t mo(input logic st, sg, ca, va, s0, c0, ifd, bs);
        out_t v;
        v = '{st, sg, ca, va, s0, c0, ifd, bs};
        return v;
    endfunction

    // Expected outputs k cycles after a clean divide start (k = 0..DC).
    function automatic out_t div_exp(input int k, input logic sg);
        logic st, s0;
        st = (k == 0);
        s0 = (k <= DC - 1);
        return mo(st, st & sg, 1'b0, k == DC, s0, 1'b0, s0, (k >= 1) && (k <= DC));
    endfunction

    task automatic apply(input in_t i);
        rst             = i.rst;
        exe_is_div      = i.div;
        exe_is_sign_div = i.sdiv;
        irq             = i.irq;
        flush           = i.flush;
        exe_load        = i.load;
        exe_wreg        = i.wreg;
        exe_dst         = i.dst;
        id_rs           = i.rs;
        id_rt           = i.rt;
    endtask

    task automatic check_out();
        sb_t  s;
        out_t got;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        s   = sb_q.pop_front();
        got = {div_start, div_signed, div_cancel, div_res_valid,
               stall0, clr0, ifid_stall, busy};
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_fail++;
            $display("FAIL %s: got st/sg/ca/va/s0/c0/ifd/bs=%b required %b (mask %b) t=%0t",
                     s.nm, got, s.e, s.m, $time);
        end
    endtask

    task automatic check_sc(input string nm, input logic [31:0] want);
        n_cmp++;
        if (stall_cycles !== want) begin
            n_fail++;
            $display("FAIL %s: stall_cycles=%0d required %0d", nm, stall_cycles, want);
        end
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic step(input in_t i, input out_t e, input out_t m, input string nm);
        out_t mm;
        mm = m;
        if (!e.st) mm.sg = 1'b0;  // div_signed only meaningful alongside div_start
        apply(i);
        sb_q.push_back('{e, mm, nm});
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{mi(0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0), mo(0,0,0,0,0,0,0,0), "idle_quiet"};
        tbl[1]  = '{mi(0,0,0,0,0,1,1, 5'd5, 5'd1, 5'd5), mo(0,0,0,0,0,1,1,0), "lu_rt"};
        tbl[2]  = '{mi(0,0,0,0,0,1,1, 5'd0, 5'd0, 5'd0), mo(0,0,0,0,0,0,0,0), "lu_dst0"};
        tbl[3]  = '{mi(0,0,0,0,0,1,1, 5'd7, 5'd7, 5'd2), mo(0,0,0,0,0,1,1,0), "lu_rs"};
        tbl[4]  = '{mi(0,0,0,0,0,1,0, 5'd5, 5'd1, 5'd5), mo(0,0,0,0,0,0,0,0), "lu_nowreg"};
        tbl[5]  = '{mi(0,0,0,0,0,0,1, 5'd5, 5'd5, 5'd5), mo(0,0,0,0,0,0,0,0), "lu_noload"};
        tbl[6]  = '{mi(0,0,0,1,0,1,1, 5'd5, 5'd5, 5'd3), mo(0,0,0,0,0,0,0,0), "lu_irq"};
        tbl[7]  = '{mi(0,0,0,0,1,1,1, 5'd5, 5'd3, 5'd5), mo(0,0,0,0,0,0,0,0), "lu_flush"};
        tbl[8]  = '{mi(0,1,1,1,0,0,0, 5'd0, 5'd0, 5'd0), mo(0,0,0,0,0,0,0,0), "div_irq"};
        tbl[9]  = '{mi(0,1,0,0,1,1,1, 5'd9, 5'd9, 5'd9), mo(0,0,0,0,0,0,0,0), "div_flush_lu"};
        tbl[10] = '{mi(0,0,0,0,0,1,1, 5'd5, 5'd6, 5'd4), mo(0,0,0,0,0,0,0,0), "lu_nomatch"};

        apply(mi(1,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0));
        @(posedge clk);
        #1;
        step(mi(1,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0), ZERO, PULSE, "reset_pulses");
        check_sc("reset_sc", 32'd0);

        // IDLE vector table: none of these may leave IDLE.
        exp_sc = 0;
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].i, tbl[k].e, ALL, tbl[k].nm);
            if (tbl[k].e.s0 || tbl[k].e.c0) exp_sc++;
        end
        check_sc("table_sc", 32'(exp_sc));
        step(mi(1,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0), ZERO, PULSE, "reset2");
        check_sc("reset2_sc", 32'd0);

        // Single signed divide, no kill.
        for (int c = 0; c <= DC + 1; c++)
            step(mi(0, c <= DC, 1, 0,0,0,0, 5'd0, 5'd0, 5'd0),
                 (c <= DC) ? div_exp(c, 1'b1) : ZERO, ALL, "single_div");
        check_sc("single_div_sc", 32'd33);

        // irq at BUSY cycle 10, then a fresh div proves IDLE, then reset at cnt=15.
        for (int c = 0; c <= 11; c++) begin
            out_t e;
            e = (c == 10) ? mo(0,0,1,0,0,0,0,1) : (c == 11) ? ZERO : div_exp(c, 1'b1);
            step(mi(0, c <= 10, 1, c == 10, 0,0,0, 5'd0, 5'd0, 5'd0), e, ALL, "irq_cancel");
        end
        for (int k = 0; k < 18; k++)
            step(mi(0,1,0,0,0,0,0, 5'd0, 5'd0, 5'd0), div_exp(k, 1'b0), ALL, "div_pre_rst");
        step(mi(1,1,0,0,0,0,0, 5'd0, 5'd0, 5'd0), ZERO, PULSE, "rst_midbusy");
        step(mi(0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0), ZERO, ALL, "after_rst");
        check_sc("after_rst_sc", 32'd0);

        // Flush landing on the completion cycle: cancel, never a result strobe.
        for (int c = 0; c <= DC + 1; c++) begin
            out_t e;
            e = (c == DC) ? mo(0,0,1,0,0,0,0,1) : (c > DC) ? ZERO : div_exp(c, 1'b0);
            step(mi(0, c <= DC, 0, 0, c == DC, 0,0, 5'd0, 5'd0, 5'd0), e, ALL, "kill_at_done");
        end

        // Back-to-back divides with a load-use hazard held during the first stall.
        for (int c = 0; c <= 2 * DC + 2; c++) begin
            out_t e;
            logic h;
            h = (c >= 1) && (c <= 20);
            if (c <= DC)            e = div_exp(c, 1'b1);
            else if (c <= 2*DC + 1) e = div_exp(c - DC - 1, 1'b0);
            else                    e = ZERO;
            step(mi(0, c <= 2*DC + 1, c <= DC, 0, 0, h, h, 5'd7, 5'd7, 5'd3),
                 e, ALL, "back_to_back");
        end

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
